// File: rtl/mcpu_mem_bridge.sv
// CPU-to-memory/IO bridge: one access at a time, sub-word reads extracted and extended,
// sub-word writes done as read-modify-write; bus phases abort to ERR after TIMEOUT stalls.
module mcpu_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int RMW_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              CPU_MIO,
  output logic              mem_w,
  output logic [ADDR_W-1:0] Addr_out,
  output logic [31:0]       Data_out,
  input  logic [31:0]       Data_in,
  input  logic              MIO_ready,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              cap_err;
  logic [31:0]       rd_ext;
  logic [31:0]       wr_merged;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic u, input logic [1:0] a);
    logic [31:0] s;
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      s = w >> {a, 3'b000};
      r = {{24{~u & s[7]}}, s[7:0]};
    end else if (sz == 2'b01) begin
      s = w >> {a[1], 4'b0000};
      r = {{16{~u & s[15]}}, s[15:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] m;
    logic [31:0] r;
    r = d;
    if (sz == 2'b00) begin
      m = 32'h0000_00FF << {a, 3'b000};
      r = (w & ~m) | ({24'd0, d[7:0]} << {a, 3'b000});
    end else if (sz == 2'b01) begin
      m = 32'h0000_FFFF << {a[1], 4'b0000};
      r = (w & ~m) | ({16'd0, d[15:0]} << {a[1], 4'b0000});
    end
    return r;
  endfunction

  assign cap_err = (size == 2'b11)
                || (size == 2'b01 && addr[0])
                || (size == 2'b10 && addr[1:0] != 2'b00)
                || (we && size != 2'b10 && RMW_EN == 0);

  assign rd_ext    = extract(Data_in, size_q, uns_q, addr_q[1:0]);
  assign wr_merged = merge(word_q, wdata_q, size_q, addr_q[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d = 8'd0;
          if (cap_err)                     state_d = S_ERR;
          else if (we && size == 2'b10)    state_d = S_WR;
          else                             state_d = S_RD;
        end
      end
      S_RD: begin
        if (MIO_ready) begin
          cnt_d   = 8'd0;
          state_d = we_q ? S_WR : S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_CNT) state_d = S_ERR;
        end
      end
      S_WR: begin
        if (MIO_ready) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_CNT) state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are frozen for the whole access; rdata only moves on a successful read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (state_q == S_IDLE && req) begin
        addr_q  <= addr;
        we_q    <= we;
        size_q  <= size;
        uns_q   <= uns;
        wdata_q <= wdata;
      end
      if (state_q == S_RD && MIO_ready) begin
        word_q <= Data_in;
        if (!we_q) rdata_q <= rd_ext;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign CPU_MIO  = (state_q == S_RD) || (state_q == S_WR);
  assign mem_w    = (state_q == S_WR);
  assign Addr_out = CPU_MIO ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign Data_out = mem_w ? ((size_q == 2'b10) ? wdata_q : wr_merged) : 32'd0;
  assign done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign err      = (state_q == S_ERR);
  assign rdata    = rdata_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mcpu_mem_bridge.sv
// Scoreboarded random bench for mcpu_mem_bridge with an arithmetic reference model
// and a responder memory that inserts random ready stalls.
module tb_mcpu_mem_bridge;
  localparam int TO = 4;

  logic        clk, reset, req, we, uns, done, err, busy, CPU_MIO, mem_w, MIO_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, Addr_out, Data_out, Data_in;
  logic [2:0]  state;

  mcpu_mem_bridge #(.ADDR_W(32), .TIMEOUT(TO), .RMW_EN(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .CPU_MIO(CPU_MIO), .mem_w(mem_w), .Addr_out(Addr_out), .Data_out(Data_out),
    .Data_in(Data_in), .MIO_ready(MIO_ready), .state(state)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic        bus;
    int          issue;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem [16];
  logic [31:0] model_mem [16];
  logic [31:0] last_rdata;
  int          total = 0, bad = 0, cyc = 0, mode = 0, wcnt = 0;
  bit          bus_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req_v);
    end
  endtask

  function automatic logic [31:0] ref_extract(input logic [31:0] w, input int sz, input bit u,
                                              input int off);
    int nb;
    longint unsigned full, v;
    nb   = 1 << sz;
    full = 64'd1 << (8 * nb);
    v    = ({32'd0, w} >> (8 * off)) % full;
    if (!u && v >= full / 2) v = v + (64'h1_0000_0000 - full);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] d,
                                            input int sz, input int off);
    int nb;
    longint unsigned lane, m, n;
    nb   = 1 << sz;
    lane = (64'd1 << (8 * nb)) - 1;
    m    = lane << (8 * off);
    n    = ({32'd0, w} & ~m) | (({32'd0, d} & lane) << (8 * off));
    return n[31:0];
  endfunction

  // Responder memory; write handshakes are checked the negedge before they complete.
  always @(negedge clk) begin
    if (!CPU_MIO || mode == 2) begin
      MIO_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (MIO_ready) wcnt = 0;
      if (mode == 0) MIO_ready = 1'b1;
      else begin
        MIO_ready = (wcnt >= 2) || ($urandom_range(0, 1) == 1);
        if (!MIO_ready) wcnt++;
      end
    end
    Data_in = CPU_MIO ? mem[Addr_out[5:2]] : $urandom;
    if (reset && mem_w && MIO_ready) begin
      if (wr_q.size() == 0) check("wr_unexpected", {31'd0, mem_w}, 32'd0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_addr", Addr_out, w.addr);
        check("wr_data", Data_out, w.data);
      end
      mem[Addr_out[5:2]] = Data_out;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (reset) begin
      if (CPU_MIO) bus_seen = 1'b1;
      if (state != 3'd1 && state != 3'd2)
        check("bus_idle", {28'd0, CPU_MIO, mem_w, |Addr_out, |Data_out}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) check("done_unexpected", {31'd0, done}, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("err", {31'd0, err}, {31'd0, e.err});
          check("rdata", rdata, e.rdata);
          check("bus_activity", {31'd0, bus_seen}, {31'd0, e.bus});
          check("bus_at_done", {31'd0, CPU_MIO}, 32'd0);
          if (e.lat >= 0) check("latency", 32'(cyc - e.issue), 32'(e.lat));
          bus_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                       input logic [31:0] wd, input int md);
    exp_t e;
    wr_t  wv;
    bit   ce;
    logic [31:0] old, nw;
    mode = md;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    ce = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.issue = cyc;
    e.bus   = !ce;
    e.err   = 1'b1;
    if (ce) e.lat = 1;
    else if (md == 2) e.lat = TO + 1;
    else begin
      e.err = 1'b0;
      old = model_mem[a[5:2]];
      if (!w) begin
        last_rdata = ref_extract(old, int'(sz), u, int'(a[1:0]));
        e.lat = 2;
      end else begin
        nw = ref_merge(old, wd, int'(sz), int'(a[1:0]));
        model_mem[a[5:2]] = nw;
        wv.addr = a & 32'hFFFF_FFFC;
        wv.data = nw;
        wr_q.push_back(wv);
        e.lat = (sz == 2'b10) ? 2 : 3;
      end
      if (md != 0) e.lat = -1;
    end
    e.rdata = last_rdata;
    exp_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Waits for IDLE while throwing ignored requests at the busy bridge.
  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (!busy) ok = 1;
      else begin
        req = 1'($urandom); we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        addr = 32'h100 + ($urandom % 64); wdata = $urandom;
        @(negedge clk);
      end
    end
    req = 1'b0;
    if (!ok) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    mem[i] = v;
    model_mem[i] = v;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0; Data_in = 32'd0; MIO_ready = 1'b0;
    last_rdata = 32'd0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    repeat (2) @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ctl", {27'd0, done, err, busy, CPU_MIO, mem_w}, 32'd0);
    check("rst_bus", Addr_out | Data_out, 32'd0);

    reset = 1'b1;
    set_word(0, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h100, 32'd0, 0);
    check("word_rd_addr", Addr_out, 32'h100);
    wait_idle();
    check("word_rd_data", rdata, 32'hDEADBEEF);

    set_word(0, 32'h80123456);
    issue(0, 2'b00, 0, 32'h103, 32'd0, 0);
    wait_idle();
    check("byte_signed", rdata, 32'hFFFFFF80);
    issue(0, 2'b00, 1, 32'h103, 32'd0, 0);
    wait_idle();
    check("byte_unsigned", rdata, 32'h00000080);

    set_word(0, 32'h11223344);
    issue(1, 2'b01, 0, 32'h202, 32'hFFFFABCD, 0);
    check("rmw_rd_no_memw", {31'd0, mem_w}, 32'd0);
    @(negedge clk);
    check("rmw_wr_data", Data_out, 32'hABCD3344);
    check("rmw_wr_memw", {31'd0, mem_w}, 32'd1);
    wait_idle();
    issue(0, 2'b10, 0, 32'h200, 32'd0, 0);
    wait_idle();
    check("rmw_readback", rdata, 32'hABCD3344);

    issue(0, 2'b01, 0, 32'h201, 32'd0, 0);
    check("misalign_pulse", {30'd0, done, err}, 32'd3);
    check("misalign_nobus", {31'd0, CPU_MIO}, 32'd0);
    wait_idle();

    issue(1, 2'b10, 0, 32'h104, 32'h55AA55AA, 2);
    wait_idle();
    check("timeout_bus_released", {31'd0, CPU_MIO}, 32'd0);

    issue(0, 2'b10, 0, 32'h108, 32'd0, 2);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_bus", {30'd0, CPU_MIO, busy}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    exp_q.delete();
    wr_q.delete();
    last_rdata = 32'd0;
    bus_seen = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    issue(0, 2'b10, 0, 32'h10C, 32'd0, 0);
    wait_idle();
    check("post_rst_read", rdata, model_mem[3]);

    for (int n = 0; n < 300; n++) begin
      bit          w;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r, md;
      w  = 1'($urandom);
      r  = $urandom % 16;
      sz = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      a  = 32'h100 + ($urandom % 64);
      if ($urandom % 4 != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      md = ($urandom % 20 == 0) ? 2 : int'($urandom % 2);
      issue(w, sz, 1'($urandom), a, $urandom, md);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
